// File: rtl/rast_pkg.sv
// Shared rasterizer types, widths and the subsample step decode.
package rast_pkg;

    localparam int SIGFIG = 24;
    localparam int RADIX  = 10;
    localparam int VERTS  = 3;
    localparam int AXIS   = 3;
    localparam int COLORS = 3;

    typedef enum logic {WAIT, TEST} iter_state_t;

    // One signed fixed-point position component and one colour channel.
    typedef logic signed [SIGFIG-1:0] coord_t;
    typedef logic        [SIGFIG-1:0] chan_t;

    // Grid spacing in fixed point for the one-hot subsample mode.
    // Bit 0 is the finest grid (8 per pixel), bit 3 is one per pixel.
    function automatic logic [SIGFIG-1:0] ss_step(input logic [3:0] subSample, input int radix);
        logic [SIGFIG-1:0] one;
        int                lg2;
        one = 1;
        if (subSample[0])      lg2 = 3;
        else if (subSample[1]) lg2 = 2;
        else if (subSample[2]) lg2 = 1;
        else                   lg2 = 0;
        return one << (radix - lg2);
    endfunction

endpackage

// File: rtl/sample_step_gen.sv
// Raster-order advance for the sample walker: next x/y and last-sample detect.
module sample_step_gen
    import rast_pkg::*;
(
    input  coord_t            x_i,
    input  coord_t            y_i,
    input  coord_t            llX_i,
    input  coord_t            urX_i,
    input  coord_t            urY_i,
    input  logic [SIGFIG-1:0] step_i,
    output coord_t            nextX_o,
    output coord_t            nextY_o,
    output logic              atEnd_o
);

    logic signed [SIGFIG:0] stepWide;
    logic signed [SIGFIG:0] xPlus;
    logic signed [SIGFIG:0] yPlus;
    logic signed [SIGFIG:0] urXWide;
    logic signed [SIGFIG:0] urYWide;
    logic                   xFits;
    logic                   yFits;

    // One extra bit so a box at the top of the signed range never wraps.
    assign stepWide = $signed({1'b0, step_i});
    assign xPlus    = $signed({x_i[SIGFIG-1], x_i}) + stepWide;
    assign yPlus    = $signed({y_i[SIGFIG-1], y_i}) + stepWide;
    assign urXWide  = $signed({urX_i[SIGFIG-1], urX_i});
    assign urYWide  = $signed({urY_i[SIGFIG-1], urY_i});

    assign xFits = (xPlus <= urXWide);
    assign yFits = (yPlus <= urYWide);

    // Step right along the row, otherwise wrap to the left edge of the next row.
    assign nextX_o = xFits ? coord_t'(xPlus[SIGFIG-1:0]) : llX_i;
    assign nextY_o = xFits ? y_i : coord_t'(yPlus[SIGFIG-1:0]);
    assign atEnd_o = !xFits && !yFits;

endmodule

// File: rtl/sample_iterator.sv
// Walks every subsample position of a triangle's bounding box in raster
// order, one candidate per clock, halting the bbox stage while busy.
module sample_iterator
    import rast_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  coord_t      tri_R13S   [VERTS][AXIS],
    input  chan_t       color_R13U [COLORS],
    input  coord_t      box_R13S   [2][2],
    input  logic        validTri_R13H,
    input  chan_t       screen_RnnnnS [2],
    input  logic [3:0]  subSample_RnnnnU,
    output logic        halt_RnnnH,
    output coord_t      tri_R14S   [VERTS][AXIS],
    output chan_t       color_R14U [COLORS],
    output coord_t      sample_R14S [2],
    output logic        validSamp_R14H
);

    iter_state_t       state_q, state_d;
    logic              valid_q, valid_d;
    coord_t            x_q, x_d;
    coord_t            y_q, y_d;
    coord_t            llX_q, urX_q, urY_q;
    coord_t            tri_q   [VERTS][AXIS];
    chan_t             color_q [COLORS];
    logic [SIGFIG-1:0] step;
    coord_t            nextX, nextY;
    logic              atEnd;
    logic              accept;
    logic              singleSample;
    logic              screenUnused;

    // The box arrives already snapped and clipped, so screen size is not needed here.
    assign screenUnused = ^{screen_RnnnnS[0], screen_RnnnnS[1]};

    assign step = ss_step(subSample_RnnnnU, RADIX);

    sample_step_gen stepGen (
        .x_i     (x_q),
        .y_i     (y_q),
        .llX_i   (llX_q),
        .urX_i   (urX_q),
        .urY_i   (urY_q),
        .step_i  (step),
        .nextX_o (nextX),
        .nextY_o (nextY),
        .atEnd_o (atEnd)
    );

    // Hold upstream until the last sample is on the output; that cycle may accept the next triangle.
    assign halt_RnnnH   = (state_q == TEST) && !atEnd;
    assign accept       = validTri_R13H && !halt_RnnnH;
    assign singleSample = (box_R13S[0][0] == box_R13S[1][0]) && (box_R13S[0][1] == box_R13S[1][1]);

    // Next sample position, valid flag and walker state.
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        x_d     = x_q;
        y_d     = y_q;
        if (accept) begin
            x_d     = box_R13S[0][0];
            y_d     = box_R13S[0][1];
            valid_d = 1'b1;
            state_d = singleSample ? WAIT : TEST;
        end else if ((state_q == TEST) && !atEnd) begin
            x_d     = nextX;
            y_d     = nextY;
            valid_d = 1'b1;
        end else begin
            valid_d = 1'b0;
            state_d = WAIT;
        end
    end

    // Walker registers; triangle, colour and box are captured only on acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WAIT;
            valid_q <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            llX_q   <= '0;
            urX_q   <= '0;
            urY_q   <= '0;
            tri_q   <= '{default: '0};
            color_q <= '{default: '0};
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            x_q     <= x_d;
            y_q     <= y_d;
            if (accept) begin
                llX_q   <= box_R13S[0][0];
                urX_q   <= box_R13S[1][0];
                urY_q   <= box_R13S[1][1];
                tri_q   <= tri_R13S;
                color_q <= color_R13U;
            end
        end
    end

    assign tri_R14S       = tri_q;
    assign color_R14U     = color_q;
    assign sample_R14S[0] = x_q;
    assign sample_R14S[1] = y_q;
    assign validSamp_R14H = valid_q;

endmodule

// File: tb/tb_sample_iterator.sv
// Directed bench for sample_iterator: raster walk, halt, back-to-back and reset abort.
module tb_sample_iterator;
    import rast_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    coord_t     triIn    [VERTS][AXIS];
    chan_t      colorIn  [COLORS];
    coord_t     boxIn    [2][2];
    logic       validTri;
    chan_t      screen   [2];
    logic [3:0] subSample;
    logic       halt;
    coord_t     triOut   [VERTS][AXIS];
    chan_t      colorOut [COLORS];
    coord_t     sampleOut [2];
    logic       validSamp;

    int checks = 0;
    int passes = 0;

    sample_iterator dut (
        .clk              (clk),
        .rst              (rst),
        .tri_R13S         (triIn),
        .color_R13U       (colorIn),
        .box_R13S         (boxIn),
        .validTri_R13H    (validTri),
        .screen_RnnnnS    (screen),
        .subSample_RnnnnU (subSample),
        .halt_RnnnH       (halt),
        .tri_R14S         (triOut),
        .color_R14U       (colorOut),
        .sample_R14S      (sampleOut),
        .validSamp_R14H   (validSamp)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed === expected) passes++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    endtask

    // Present a triangle whose vertex fields are seed+index and colour seed+10+channel.
    task automatic applyStimulus(input int llx, input int lly, input int urx, input int ury, input int seed);
        boxIn[0][0] = llx;
        boxIn[0][1] = lly;
        boxIn[1][0] = urx;
        boxIn[1][1] = ury;
        for (int v = 0; v < VERTS; v++)
            for (int a = 0; a < AXIS; a++)
                triIn[v][a] = seed + v * AXIS + a;
        for (int c = 0; c < COLORS; c++)
            colorIn[c] = seed + 10 + c;
        validTri = 1'b1;
    endtask

    // Feed one triangle and check every sample of its box in raster order, then the idle cycle.
    task automatic walkBox(input string tag, input int llx, input int lly, input int urx, input int ury,
                           input int stp, input int seed);
        bit last;
        applyStimulus(llx, lly, urx, ury, seed);
        tick();
        validTri = 1'b0;
        for (int y = lly; y <= ury; y += stp) begin
            for (int x = llx; x <= urx; x += stp) begin
                last = (x + stp > urx) && (y + stp > ury);
                checkOutput({tag, " valid"}, validSamp, 1);
                checkOutput({tag, " x"}, sampleOut[0], x);
                checkOutput({tag, " y"}, sampleOut[1], y);
                checkOutput({tag, " halt"}, halt, !last);
                checkOutput({tag, " tri"}, triOut[2][2], seed + 8);
                checkOutput({tag, " color"}, colorOut[2], seed + 12);
                tick();
            end
        end
        checkOutput({tag, " idle valid"}, validSamp, 0);
        checkOutput({tag, " idle halt"}, halt, 0);
    endtask

    int expX [6] = '{0, 1024, 2048, 0, 1024, 2048};
    int expY [6] = '{0, 0, 0, 1024, 1024, 1024};

    initial begin
        rst       = 1'b1;
        validTri  = 1'b0;
        screen[0] = 24'd8192;
        screen[1] = 24'd8192;
        subSample = 4'b1000;
        applyStimulus(0, 0, 0, 0, 0);
        validTri  = 1'b0;
        tick();
        tick();
        checkOutput("reset valid", validSamp, 0);
        checkOutput("reset halt", halt, 0);
        checkOutput("reset x", sampleOut[0], 0);
        checkOutput("reset tri", triOut[0][0], 0);
        checkOutput("reset color", colorOut[0], 0);
        rst = 1'b0;
        tick();

        // 1x step, 3x2 box from hand-listed positions
        applyStimulus(0, 0, 2048, 1024, 40);
        tick();
        validTri = 1'b0;
        for (int i = 0; i < 6; i++) begin
            checkOutput("c1 valid", validSamp, 1);
            checkOutput("c1 x", sampleOut[0], expX[i]);
            checkOutput("c1 y", sampleOut[1], expY[i]);
            checkOutput("c1 halt", halt, (i < 5) ? 1 : 0);
            tick();
        end
        checkOutput("c1 idle valid", validSamp, 0);

        // 8x subsampling, 3x3 grid
        subSample = 4'b0001;
        walkBox("c2", 0, 0, 256, 256, 128, 60);

        // single-sample box stays in WAIT
        subSample = 4'b1000;
        walkBox("c3", 1024, 1024, 1024, 1024, 1024, 80);
        tick();
        checkOutput("c3 still idle", validSamp, 0);

        // back-to-back: B held upstream, accepted on A's last sample
        applyStimulus(0, 0, 1024, 0, 100);
        tick();
        applyStimulus(2048, 1024, 2048, 2048, 200);
        checkOutput("c4 A0 x", sampleOut[0], 0);
        checkOutput("c4 A0 halt", halt, 1);
        tick();
        checkOutput("c4 A1 x", sampleOut[0], 1024);
        checkOutput("c4 A1 halt", halt, 0);
        checkOutput("c4 A1 tri", triOut[0][0], 100);
        tick();
        validTri = 1'b0;
        checkOutput("c4 B0 valid", validSamp, 1);
        checkOutput("c4 B0 x", sampleOut[0], 2048);
        checkOutput("c4 B0 y", sampleOut[1], 1024);
        checkOutput("c4 B0 tri", triOut[0][0], 200);
        checkOutput("c4 B0 halt", halt, 1);
        tick();
        checkOutput("c4 B1 y", sampleOut[1], 2048);
        checkOutput("c4 B1 halt", halt, 0);
        tick();
        checkOutput("c4 idle valid", validSamp, 0);

        // new triangle offered while halted must be ignored
        applyStimulus(0, 0, 1024, 1024, 300);
        tick();
        for (int i = 0; i < 4; i++) begin
            if (i == 0) applyStimulus(4096, 4096, 4096, 4096, 500);
            if (i == 2) validTri = 1'b0;
            checkOutput("c5 valid", validSamp, 1);
            checkOutput("c5 x", sampleOut[0], (i % 2) * 1024);
            checkOutput("c5 y", sampleOut[1], (i / 2) * 1024);
            checkOutput("c5 tri", triOut[0][0], 300);
            tick();
        end
        checkOutput("c5 idle valid", validSamp, 0);

        // box at the top of the signed range must terminate
        walkBox("top", 8386560, 0, 8387584, 0, 1024, 600);

        // reset during the third sample of the 3x2 box
        applyStimulus(0, 0, 2048, 1024, 700);
        tick();
        validTri = 1'b0;
        tick();
        tick();
        checkOutput("c6 pre x", sampleOut[0], 2048);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("c6 rst valid", validSamp, 0);
        checkOutput("c6 rst halt", halt, 0);
        checkOutput("c6 rst x", sampleOut[0], 0);
        checkOutput("c6 rst tri", triOut[0][0], 0);
        tick();
        checkOutput("c6 stays idle", validSamp, 0);
        walkBox("c6 after", 1024, 0, 2048, 0, 1024, 800);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/sample_iterator.md
Name: sample_iterator

Overview:
- Rasterizer stage between the bounding-box stage (R13) and sample test (R14 onward).
- Accepts one triangle plus its grid-aligned bounding box and walks every subsample position in the box in raster order, emitting one candidate sample per clock.
- Asserts halt back to bbox while a triangle's box is still being walked.
- Feeds the jitter hash / sample test pipe whose hits the sample-count scoreboard totals per triangle.

Parameters:
- SIGFIG, 24: bits in colour and position.
- RADIX, 10: fraction bits in position.
- VERTS, 3: vertices per triangle.
- AXIS, 3: axes per vertex (x, y, z).
- COLORS, 3: colour channels.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- tri_R13S  in  signed [SIGFIG-1:0] [VERTS][AXIS]  triangle from bbox
- color_R13U  in  [SIGFIG-1:0] [COLORS]  triangle colour
- box_R13S  in  signed [SIGFIG-1:0] [2][2]  box; [0]=lower-left, [1]=upper-right; [i][0]=x, [i][1]=y
- validTri_R13H  in  1  triangle/box valid
- screen_RnnnnS  in  [SIGFIG-1:0] [2]  screen size (static)
- subSample_RnnnnU  in  4  one-hot subsample mode (static)
- halt_RnnnH  out  1  upstream must hold its R13 outputs
- tri_R14S  out  signed [SIGFIG-1:0] [VERTS][AXIS]  current triangle
- color_R14U  out  [SIGFIG-1:0] [COLORS]  current colour
- sample_R14S  out  signed [SIGFIG-1:0] [2]  sample x, y
- validSamp_R14H  out  1  sample valid

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: state=WAIT, halt_RnnnH=0, validSamp_R14H=0, all data outputs 0.
- Reset wins over any simultaneous input and aborts an iteration in progress; no further samples are emitted for that triangle.
- Subsample decode: ss_w_lg2 = 3/2/1/0 for subSample_RnnnnU bit 0/1/2/3. step = 1 << (RADIX - ss_w_lg2); RADIX=10 gives 128/256/512/1024.
- Box corners are already snapped to multiples of step and clipped to the screen by bbox. The iterator never re-aligns or clips.
- FSM states: WAIT, TEST.
- WAIT:
  - halt_RnnnH=0.
  - If validTri_R13H: register tri, color and box; sample_R14S = box lower-left; validSamp_R14H=1 next cycle; go to TEST, unless lower-left == upper-right (single-sample box), in which case stay in WAIT.
  - Otherwise validSamp_R14H=0.
- TEST:
  - validSamp_R14H=1 every cycle.
  - Advance rule: if x + step <= ur_x then x += step; else x = ll_x and y += step.
  - at_end = (x + step > ur_x) && (y + step > ur_y), evaluated on the sample currently presented.
  - halt_RnnnH = !at_end, combinational from registered state. Upstream therefore may present the next triangle during the last-sample cycle.
  - On at_end with validTri_R13H=1: load the new triangle/box and emit its lower-left next cycle, with no bubble. Stay in TEST unless the new box is single-sample.
  - On at_end with validTri_R13H=0: go to WAIT; validSamp_R14H=0 next cycle.
- When halt_RnnnH=1, validTri_R13H is ignored (not latched).
- Latency: triangle accepted at edge N gives its first sample valid after edge N+1.
- Sample count per triangle = ((ur_x-ll_x)/step + 1) * ((ur_y-ll_y)/step + 1).
- Arithmetic: x+step and y+step are computed in SIGFIG+1 signed bits, so a box touching the top of the signed range never wraps.
- tri_R14S and color_R14U stay constant for every sample of one triangle.

Decomposition:
- Shared package rast_pkg:
  - typedef enum {WAIT, TEST} iter_state_t
  - function ss_step(subSample, RADIX), returning step
  - typedefs for sample/box/vertex arrays
- Registers use the existing dff/dff2/dff3 library cells.
- One small sub-module is natural: sample_step_gen, holding the x/y advance, wrap and at_end compare.

Test Plan (RADIX=10, SIGFIG=24):
1. subSample=4'b1000, box (0,0)-(2048,1024) -> samples (0,0), (1024,0), (2048,0), (0,1024), (1024,1024), (2048,1024) on consecutive cycles; halt=1 for the first 5, halt=0 on the 6th; then validSamp=0.
2. subSample=4'b0001, box (0,0)-(256,256) -> 9 samples, step 128, x wraps to 0 after 256; halt never drops mid-row.
3. Single-sample box (1024,1024)-(1024,1024) -> exactly one valid sample; halt stays 0; FSM remains in WAIT.
4. Back-to-back: tri A 2x1 box, tri B presented on A's last-sample cycle -> B's lower-left appears the very next cycle with no bubble; tri_R14S switches exactly at that boundary.
5. validTri=1 with a different triangle while halt=1 -> ignored; the current triangle's sample sequence and count are unchanged.
6. Assert rst on the 3rd sample of case 1 -> next cycle validSamp=0, halt=0, outputs 0; a triangle presented after reset iterates from its lower-left.
